// File: rtl/conv_bram_result_drain.sv
// Result drain for the striped-BRAM convolution engine: requantises per-filter
// accumulators into per-channel RAMs, then streams a full frame out channel-major.
module conv_bram_result_drain #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RESULT_W   = 6,
    parameter int unsigned RESULT_H   = 6,
    parameter int unsigned RESULT_D   = 8,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned RELU       = 1,
    localparam int unsigned RES_WIDTH             = 4 * DATA_WIDTH,
    localparam int unsigned RESULT_N              = RESULT_W * RESULT_H,
    localparam int unsigned RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_N),
    localparam int unsigned CH_ADDR_WIDTH         = (RESULT_D > 1) ? $clog2(RESULT_D) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_wraddress,
    input  logic [RES_WIDTH*RESULT_D-1:0]             result_data_out,
    input  logic [RESULT_D-1:0]                       result_wren,
    output logic [DATA_WIDTH-1:0]                     out_data,
    output logic [CH_ADDR_WIDTH-1:0]                  out_ch,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0]          out_addr,
    output logic                                      out_val,
    input  logic                                      out_rdy,
    output logic                                      frame_done,
    output logic                                      busy,
    output logic                                      overflow
);

    localparam int unsigned RA_W  = RESULT_RAM_ADDR_WIDTH;
    localparam int unsigned CH_W  = CH_ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(RESULT_N + 1);

    localparam logic signed [RES_WIDTH-1:0] Q_MAX =
        {{(RES_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RES_WIDTH-1:0] Q_MIN =
        {{(RES_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Floor shift, optional ReLU, then saturate to the signed output range.
    function automatic logic [DATA_WIDTH-1:0] quantise(input logic [RES_WIDTH-1:0] acc);
        logic signed [RES_WIDTH-1:0] q;
        q = $signed(acc) >>> SHIFT;
        if ((RELU != 0) && (q < 0)) begin
            q = '0;
        end
        if (q > Q_MAX) begin
            quantise = Q_MAX[DATA_WIDTH-1:0];
        end else if (q < Q_MIN) begin
            quantise = Q_MIN[DATA_WIDTH-1:0];
        end else begin
            quantise = q[DATA_WIDTH-1:0];
        end
    endfunction

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [CH_W-1:0]                      ch_q, ch_d;
    logic [RA_W-1:0]                      addr_q, addr_d;
    logic                                 issue_q, issue_d;
    logic                                 out_val_q, out_val_d;
    logic [DATA_WIDTH-1:0]                out_data_q, out_data_d;
    logic [CH_W-1:0]                      out_ch_q, out_ch_d;
    logic [RA_W-1:0]                      out_addr_q, out_addr_d;
    logic                                 frame_done_q, frame_done_d;
    logic                                 busy_q, busy_d;
    logic                                 overflow_q, overflow_d;

    logic [RESULT_D-1:0][DATA_WIDTH-1:0]  s1_data_q, s1_data_d;
    logic [RESULT_D-1:0][RA_W-1:0]        s1_addr_q, s1_addr_d;
    logic [RESULT_D-1:0]                  s1_wren_q, s1_wren_d;

    logic [RESULT_D-1:0][DATA_WIDTH-1:0]  rd_word_c;
    logic [DATA_WIDTH-1:0]                rd_data_c;

    // Per-channel quantiser (stage 1 input) and result RAM (stage 2 write, async-indexed read).
    for (genvar k = 0; k < RESULT_D; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [RESULT_N];

        always_comb begin
            s1_data_d[k] = quantise(result_data_out[k*RES_WIDTH +: RES_WIDTH]);
            s1_addr_d[k] = result_wraddress[k*RA_W +: RA_W];
        end

        always_ff @(posedge clk) begin
            if (s1_wren_q[k]) begin
                mem[s1_addr_q[k]] <= s1_data_q[k];
            end
        end

        assign rd_word_c[k] = mem[addr_q];
    end

    assign rd_data_c = rd_word_c[ch_q];

    // Enables outside FILL never reach the RAMs.
    always_comb begin
        s1_wren_d = '0;
        if (state_q == S_FILL) begin
            s1_wren_d = result_wren;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_data_q <= '0;
            s1_addr_q <= '0;
            s1_wren_q <= '0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_addr_q <= s1_addr_d;
            s1_wren_q <= s1_wren_d;
        end
    end

    // Frame FSM: fill counting, one-cycle commit wait, then handshaked drain.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        addr_d       = addr_q;
        issue_d      = issue_q;
        out_val_d    = out_val_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_addr_d   = out_addr_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        unique case (state_q)
            S_FILL: begin
                if (result_wren[0]) begin
                    if (cnt_q == CNT_W'(RESULT_N - 1)) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                state_d = S_DRAIN;
                ch_d    = '0;
                addr_d  = '0;
                issue_d = 1'b0;
            end
            S_DRAIN: begin
                if (issue_q) begin
                    issue_d    = 1'b0;
                    out_val_d  = 1'b1;
                    out_data_d = rd_data_c;
                    out_ch_d   = ch_q;
                    out_addr_d = addr_q;
                end else if (out_val_q) begin
                    if (out_rdy) begin
                        out_val_d = 1'b0;
                        if (addr_q == RA_W'(RESULT_N - 1)) begin
                            addr_d = '0;
                            if (ch_q == CH_W'(RESULT_D - 1)) begin
                                ch_d         = '0;
                                frame_done_d = 1'b1;
                                state_d      = S_FILL;
                            end else begin
                                ch_d    = ch_q + CH_W'(1);
                                issue_d = 1'b1;
                            end
                        end else begin
                            addr_d  = addr_q + RA_W'(1);
                            issue_d = 1'b1;
                        end
                    end
                end else begin
                    // First read of the frame is issued one cycle after entry.
                    issue_d = 1'b1;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        if ((state_q != S_FILL) && (|result_wren)) begin
            overflow_d = 1'b1;
        end

        busy_d = (state_d != S_FILL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FILL;
            cnt_q        <= '0;
            ch_q         <= '0;
            addr_q       <= '0;
            issue_q      <= 1'b0;
            out_val_q    <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_addr_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            addr_q       <= addr_d;
            issue_q      <= issue_d;
            out_val_q    <= out_val_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_addr_q   <= out_addr_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_addr   = out_addr_q;
    assign out_val    = out_val_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_bram_result_drain.sv
// Randomised bench for conv_bram_result_drain: two instances (ReLU off/on) share
// stimulus and are compared against an arithmetic requantise-and-order model.
module tb_conv_bram_result_drain;

    localparam int DW  = 8;
    localparam int RW  = 32;
    localparam int W   = 2;
    localparam int H   = 2;
    localparam int D   = 2;
    localparam int N   = W * H;
    localparam int RA  = 2;
    localparam int CHW = 1;
    localparam int SH  = 4;

    logic               clk;
    logic               reset;
    logic [RA*D-1:0]    wraddr;
    logic [RW*D-1:0]    wdata;
    logic [D-1:0]       wren;
    logic               out_rdy;

    logic [DW-1:0]      o0_data, o1_data;
    logic [CHW-1:0]     o0_ch, o1_ch;
    logic [RA-1:0]      o0_addr, o1_addr;
    logic               o0_val, o1_val;
    logic               o0_done, o1_done;
    logic               o0_busy, o1_busy;
    logic               o0_ovf, o1_ovf;

    logic [31:0]        acc_m [D][N];
    int                 n_chk;
    int                 n_pass;

    conv_bram_result_drain #(
        .DATA_WIDTH(DW), .RESULT_W(W), .RESULT_H(H), .RESULT_D(D), .SHIFT(SH), .RELU(0)
    ) u_dut (
        .clk(clk), .reset(reset),
        .result_wraddress(wraddr), .result_data_out(wdata), .result_wren(wren),
        .out_data(o0_data), .out_ch(o0_ch), .out_addr(o0_addr), .out_val(o0_val),
        .out_rdy(out_rdy), .frame_done(o0_done), .busy(o0_busy), .overflow(o0_ovf)
    );

    conv_bram_result_drain #(
        .DATA_WIDTH(DW), .RESULT_W(W), .RESULT_H(H), .RESULT_D(D), .SHIFT(SH), .RELU(1)
    ) u_relu (
        .clk(clk), .reset(reset),
        .result_wraddress(wraddr), .result_data_out(wdata), .result_wren(wren),
        .out_data(o1_data), .out_ch(o1_ch), .out_addr(o1_addr), .out_val(o1_val),
        .out_rdy(out_rdy), .frame_done(o1_done), .busy(o1_busy), .overflow(o1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference requantiser: floor division by 2^SH, optional ReLU, clamp to int8.
    function automatic logic [DW-1:0] model_q(input logic [31:0] acc, input bit relu);
        longint a;
        longint q;
        longint div;
        div = longint'(1) << SH;
        a   = longint'($signed(acc));
        q   = a / div;
        if ((a % div != 0) && (a < 0)) q = q - 1;
        if (relu && (q < 0)) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        model_q = DW'(q);
    endfunction

    function automatic logic [31:0] rand_acc();
        int v;
        case ($urandom_range(0, 3))
            0: rand_acc = $urandom;
            1: begin
                v = int'($urandom_range(0, 8191)) - 4096;
                rand_acc = 32'(v);
            end
            2: rand_acc = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: begin
                v = int'($urandom_range(1990, 2100));
                if ($urandom_range(0, 1) != 0) v = -v;
                rand_acc = 32'(v);
            end
        endcase
    endfunction

    task automatic randomize_frame();
        for (int c = 0; c < D; c++) begin
            for (int a = 0; a < N; a++) begin
                acc_m[c][a] = rand_acc();
            end
        end
    endtask

    // Write one frame in the given address order (0 fwd, 1 reverse, 2 shuffled), then check drain latency.
    task automatic fill(input int order_mode);
        int ord [N];
        int j;
        int t;
        for (int i = 0; i < N; i++) ord[i] = (order_mode == 1) ? (N - 1 - i) : i;
        if (order_mode == 2) begin
            for (int i = N - 1; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < D; c++) begin
                wraddr[c*RA +: RA] = RA'(ord[i]);
                wdata[c*RW +: RW]  = acc_m[c][ord[i]];
            end
            wren = '1;
            if (i == N - 1) chk("busy_before_last", 32'(o0_busy), 32'(0));
            tick();
            wren = '0;
            if (i < N - 1) repeat ($urandom_range(0, 2)) tick();
        end
        chk("busy_e0", 32'(o0_busy), 32'(1));
        chk("val_e0", 32'(o0_val), 32'(0));
        tick();
        chk("val_e1", 32'(o0_val), 32'(0));
        tick();
        chk("val_e2", 32'(o0_val), 32'(0));
        tick();
        chk("val_e3", 32'(o0_val), 32'(1));
    endtask

    // Accept elements under an out_rdy pattern; stop_after>0 ends early without frame-end checks.
    task automatic drain(input int rdy_mode, input bit inject, input int stop_after);
        int  idx;
        int  lim;
        int  ec;
        int  ea;
        bit  rdy;
        bit  prev_hs;
        bit  prev_stall;
        idx = 0;
        lim = (stop_after > 0) ? stop_after : N * D;
        prev_hs = 1'b0;
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 300 && idx < lim; cyc++) begin
            case (rdy_mode)
                0: rdy = 1'b1;
                1: rdy = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_rdy = rdy;
            if (inject && cyc == 3) begin
                wren = '1;
                for (int c = 0; c < D; c++) begin
                    wraddr[c*RA +: RA] = RA'(N - 1);
                    wdata[c*RW +: RW]  = $urandom;
                end
            end else begin
                wren = '0;
            end
            if (prev_hs) chk("gap_after_accept", 32'(o0_val), 32'(0));
            if (prev_stall) chk("val_held_in_stall", 32'(o0_val), 32'(1));
            if (o0_val) begin
                ec = idx / N;
                ea = idx % N;
                chk("data", 32'(o0_data), 32'(model_q(acc_m[ec][ea], 1'b0)));
                chk("relu_data", 32'(o1_data), 32'(model_q(acc_m[ec][ea], 1'b1)));
                chk("ch", 32'(o0_ch), 32'(ec));
                chk("addr", 32'(o0_addr), 32'(ea));
                chk("relu_val", 32'(o1_val), 32'(1));
            end
            prev_hs    = o0_val && rdy;
            prev_stall = o0_val && !rdy;
            if (prev_hs) idx++;
            tick();
        end
        wren = '0;
        if (idx < lim) chk("drain_timeout", 32'(idx), 32'(lim));
        if (stop_after == 0) begin
            chk("frame_done", 32'(o0_done), 32'(1));
            chk("relu_frame_done", 32'(o1_done), 32'(1));
            chk("busy_after_frame", 32'(o0_busy), 32'(0));
            chk("no_extra_val", 32'(o0_val), 32'(0));
            tick();
            chk("frame_done_pulse", 32'(o0_done), 32'(0));
        end
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        reset   = 1'b1;
        wren    = '0;
        wraddr  = '0;
        wdata   = '0;
        out_rdy = 1'b0;
        tick();
        tick();
        chk("rst_val", 32'(o0_val), 32'(0));
        chk("rst_busy", 32'(o0_busy), 32'(0));
        chk("rst_ovf", 32'(o0_ovf), 32'(0));
        chk("rst_done", 32'(o0_done), 32'(0));
        chk("rst_data", 32'(o0_data), 32'(0));
        chk("rst_ch", 32'(o0_ch), 32'(0));
        chk("rst_addr", 32'(o0_addr), 32'(0));
        reset = 1'b0;
        tick();

        // Directed frame, forward order, consumer always ready.
        acc_m[0][0] = 32'h0000_0330; acc_m[0][1] = 32'h0001_0000;
        acc_m[0][2] = 32'hFFFF_FF9C; acc_m[0][3] = 32'h0000_0000;
        acc_m[1][0] = 32'h0000_0010; acc_m[1][1] = 32'h0000_0020;
        acc_m[1][2] = 32'h0000_0030; acc_m[1][3] = 32'h0000_0040;
        chk("model_sanity_f9", 32'(model_q(acc_m[0][2], 1'b0)), 32'h0000_00F9);
        fill(0);
        drain(0, 1'b0, 0);
        chk("ovf_clean", 32'(o0_ovf), 32'(0));

        // Most-negative accumulator, reverse write order, 5-cycle stall at start.
        acc_m[0][0] = 32'h8000_0000;
        fill(1);
        drain(1, 1'b0, 0);

        // Stray enables mid-drain must flag overflow without touching data or count.
        randomize_frame();
        fill(2);
        drain(2, 1'b1, 0);
        chk("ovf_set", 32'(o0_ovf), 32'(1));
        chk("relu_ovf_set", 32'(o1_ovf), 32'(1));
        randomize_frame();
        fill(2);
        drain(2, 1'b0, 0);
        chk("ovf_sticky", 32'(o0_ovf), 32'(1));

        // Reset while an element is presented, then a clean frame.
        randomize_frame();
        fill(2);
        drain(2, 1'b0, 3);
        out_rdy = 1'b0;
        tick();
        chk("val_before_reset", 32'(o0_val), 32'(1));
        reset = 1'b1;
        #1;
        chk("async_rst_val", 32'(o0_val), 32'(0));
        chk("async_rst_busy", 32'(o0_busy), 32'(0));
        chk("async_rst_ovf", 32'(o0_ovf), 32'(0));
        tick();
        reset = 1'b0;
        tick();
        for (int f = 0; f < 4; f++) begin
            randomize_frame();
            fill(2);
            drain((f == 0) ? 0 : 2, 1'b0, 0);
        end
        chk("ovf_clear_after_reset", 32'(o0_ovf), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
